// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller: fetch-stage PC sequencer for the 5-stage RV32I pipe.
// Owns the PC, drives imem fetch, takes redirects and sequences pipe flushes.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   stall_i              hazard-unit stall, holds the PC in FETCH
//   br_valid/br_taken    EX branch resolution, br_target = PC-relative target
//   jalr_valid           EX JALR, target = (jalr_base + jalr_offset) & ~1
//   jal_valid            ID JAL, jal_target = PC-relative target
//   imem_ready           imem accepts the current fetch address
//   imem_req, imem_addr  fetch request / address (imem_addr = pc_o)
//   pc_o, pc_plus4_o     current fetch PC and PC + 4
//   fetch_valid          fetched word valid for IF/ID
//   flush_if_id/id_ex    squash IF/ID and ID/EX
//   redirect_cnt         count of accepted redirects (wraps)
//   trap_o, trap_tval    misaligned-target trap pulse and offending target
//
// Build option: define MISALIGN_TRAP_EN to trap on a misaligned redirect
// target (PC <- TRAP_VECTOR). Otherwise target[1:0] is forced to zero.

module pc_redirect_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_base,
  input  logic [31:0] jalr_offset,
  input  logic        jal_valid,
  input  logic [31:0] jal_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [15:0] redirect_cnt,
  output logic        trap_o,
  output logic [31:0] trap_tval
);

  // Out-of-range settings are clamped to the legal 1..3 window.
  localparam int unsigned FC_N =
    (FLUSH_CYCLES < 1) ? 1 :
    (FLUSH_CYCLES > 3) ? 3 : FLUSH_CYCLES;
  localparam logic [1:0] FC_LD = 2'(FC_N);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        req_q, req_d;
  logic        fv_q, fv_d;
  logic        flush_q, flush_d;

  logic [31:0] jalr_sum;
  logic        redir;
  logic [31:0] raw_tgt;
  logic [31:0] tgt;
  logic        take_trap;
  logic [31:0] new_pc;
  logic        take;

  assign jalr_sum = jalr_base + jalr_offset;

  // EX-stage instructions are older than the ID-stage JAL,
  // so they win when several redirects arrive together.
  always_comb begin
    redir   = 1'b0;
    raw_tgt = 32'h0;
    priority case (1'b1)
      jalr_valid: begin
        redir   = 1'b1;
        raw_tgt = jalr_sum & ~32'h1;
      end
      (br_valid && br_taken): begin
        redir   = 1'b1;
        raw_tgt = br_target;
      end
      jal_valid: begin
        redir   = 1'b1;
        raw_tgt = jal_target;
      end
      default: begin
        redir   = 1'b0;
        raw_tgt = 32'h0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign tgt       = raw_tgt;
  assign take_trap = |raw_tgt[1:0];
`else
  assign tgt       = {raw_tgt[31:2], raw_tgt[1:0] & 2'b00};
  assign take_trap = 1'b0;
`endif

  assign new_pc = take_trap ? TRAP_VECTOR : tgt;

  // Redirects are only honoured once fetching has started.
  assign take = redir && (state_q != BOOT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    fv_d    = 1'b0;
    if (take) begin
      // A redirect also overrides stall/imem_ready
      // and restarts an ongoing flush count.
      pc_d    = new_pc;
      state_d = FLUSH;
      fcnt_d  = FC_LD;
      rcnt_d  = rcnt_q + 16'd1;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (imem_ready && !stall_i) begin
            pc_d = pc_q + 32'd4;
            fv_d = 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt_q == 2'd1) begin
            state_d = FETCH;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
    req_d   = (state_d == FETCH);
    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fcnt_q  <= 2'd0;
      rcnt_q  <= 16'd0;
      req_q   <= 1'b0;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      req_q   <= req_d;
      fv_q    <= fv_d;
      flush_q <= flush_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
  logic [31:0] tval_q, tval_d;

  always_comb begin
    trap_d = take && take_trap;
    tval_d = trap_d ? raw_tgt : tval_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
      tval_q <= 32'h0;
    end else begin
      trap_q <= trap_d;
      tval_q <= tval_d;
    end
  end

  assign trap_o    = trap_q;
  assign trap_tval = tval_q;
`else
  assign trap_o    = 1'b0;
  assign trap_tval = 32'h0;
`endif

  assign pc_o         = pc_q;
  assign imem_addr    = pc_q;
  assign pc_plus4_o   = pc_q + 32'd4;
  assign imem_req     = req_q;
  assign fetch_valid  = fv_q;
  assign flush_if_id  = flush_q;
  assign flush_id_ex  = flush_q;
  assign redirect_cnt = rcnt_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller: scoreboard bench for pc_redirect_controller.
// Expected per-cycle outputs are queued with stimulus and popped after the edge.

module tb_pc_redirect_controller;

  localparam int unsigned FC = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jalr_valid;
  logic [31:0] jalr_base;
  logic [31:0] jalr_offset;
  logic        jal_valid;
  logic [31:0] jal_target;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [15:0] redirect_cnt;
  logic        trap_o;
  logic [31:0] trap_tval;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [116:0] sb[$];
  logic [116:0] obs;

  always #5 clk = ~clk;

  pc_redirect_controller #(
    .RESET_PC    (32'h0),
    .TRAP_VECTOR (32'h100),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jalr_valid  (jalr_valid),
    .jalr_base   (jalr_base),
    .jalr_offset (jalr_offset),
    .jal_valid   (jal_valid),
    .jal_target  (jal_target),
    .imem_ready  (imem_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .fetch_valid (fetch_valid),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .redirect_cnt(redirect_cnt),
    .trap_o      (trap_o),
    .trap_tval   (trap_tval)
  );

  assign obs = {pc_o, imem_addr, pc_plus4_o, fetch_valid, imem_req,
                flush_if_id, flush_id_ex, redirect_cnt, trap_o};

  // Expected observation vector for one cycle.
  function automatic logic [116:0] mk(input logic [31:0] pc,
                                      input logic fv, input logic req,
                                      input logic fl, input logic [15:0] cnt,
                                      input logic tr);
    return {pc, pc, pc + 32'd4, fv, req, fl, fl, cnt, tr};
  endfunction

  task automatic clear();
    stall_i     = 1'b0;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    jalr_valid  = 1'b0;
    jalr_base   = 32'h0;
    jalr_offset = 32'h0;
    jal_valid   = 1'b0;
    jal_target  = 32'h0;
  endtask

  task automatic test_reset();
    logic [116:0] ex;
    rst_n = 1'b0;
    imem_ready = 1'b1;
    clear();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL reset[%0d] got %h exp %h", i, obs, ex);
      end
    end
    checks++;
    if (trap_tval !== 32'h0) begin
      errors++;
      $display("FAIL reset_tval got %h exp 0", trap_tval);
    end
  endtask

  task automatic test_boot_fetch();
    logic [116:0] ex;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) sb.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
      else sb.push_back(mk(32'(4 * i), 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL boot_fetch[%0d] got %h exp %h", i, obs, ex);
      end
    end
  endtask

  task automatic test_stall();
    logic [116:0] ex;
    for (int i = 0; i < 5; i++) begin
      imem_ready = (i != 0);
      stall_i = (i >= 1 && i <= 3);
      if (i < 4) sb.push_back(mk(32'h10, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
      else sb.push_back(mk(32'h14, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL stall[%0d] got %h exp %h", i, obs, ex);
      end
    end
    imem_ready = 1'b1;
    stall_i = 1'b0;
  endtask

  task automatic test_not_taken();
    logic [116:0] ex;
    br_valid  = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'h40;
    sb.push_back(mk(32'h18, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
    @(posedge clk); #1;
    ex = sb.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL not_taken got %h exp %h", obs, ex);
    end
    clear();
  endtask

  task automatic test_branch_priority();
    logic [116:0] ex;
    br_valid   = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h40;
    jal_valid  = 1'b1;
    jal_target = 32'h80;
    exp_cnt++;
    for (int i = 0; i < int'(FC) + 2; i++) begin
      if (i == 1) clear();
      if (i < int'(FC))
        sb.push_back(mk(32'h40, 1'b0, 1'b0, 1'b1, exp_cnt, 1'b0));
      else if (i == int'(FC))
        sb.push_back(mk(32'h40, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
      else
        sb.push_back(mk(32'h44, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL branch[%0d] got %h exp %h", i, obs, ex);
      end
    end
  endtask

  task automatic test_jalr_restart();
    logic [116:0] ex;
    for (int i = 0; i < int'(FC) + 4; i++) begin
      clear();
      stall_i = (i < int'(FC) + 3);
      if (i == 0) begin
        jalr_valid  = 1'b1;
        jalr_base   = 32'h1001;
        jalr_offset = 32'hFFFF_FFFF;
        br_valid    = 1'b1;
        br_taken    = 1'b1;
        br_target   = 32'h200;
        jal_valid   = 1'b1;
        jal_target  = 32'h300;
        exp_cnt++;
      end else if (i == 1) begin
        jal_valid  = 1'b1;
        jal_target = 32'h2000;
        exp_cnt++;
      end
      if (i == 0)
        sb.push_back(mk(32'h1000, 1'b0, 1'b0, 1'b1, exp_cnt, 1'b0));
      else if (i <= int'(FC))
        sb.push_back(mk(32'h2000, 1'b0, 1'b0, 1'b1, exp_cnt, 1'b0));
      else if (i <= int'(FC) + 2)
        sb.push_back(mk(32'h2000, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
      else
        sb.push_back(mk(32'h2004, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL jalr[%0d] got %h exp %h", i, obs, ex);
      end
    end
    clear();
  endtask

  task automatic test_misalign();
    logic [116:0] ex;
    jal_valid  = 1'b1;
    jal_target = 32'h102;
    exp_cnt++;
    for (int i = 0; i < int'(FC) + 2; i++) begin
      if (i == 1) clear();
      if (i < int'(FC))
        sb.push_back(mk(32'h100, 1'b0, 1'b0, 1'b1, exp_cnt,
                        (i == 0) ? TRAP_ON : 1'b0));
      else if (i == int'(FC))
        sb.push_back(mk(32'h100, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
      else
        sb.push_back(mk(32'h104, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL misalign[%0d] got %h exp %h", i, obs, ex);
      end
      if (i == 0) begin
        checks++;
        if (trap_tval !== (TRAP_ON ? 32'h102 : 32'h0)) begin
          errors++;
          $display("FAIL misalign_tval got %h exp %h", trap_tval,
                   TRAP_ON ? 32'h102 : 32'h0);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [116:0] ex;
    jal_valid  = 1'b1;
    jal_target = 32'hFFFF_FFFC;
    exp_cnt++;
    for (int i = 0; i < int'(FC) + 2; i++) begin
      if (i == 1) clear();
      if (i < int'(FC))
        sb.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, exp_cnt, 1'b0));
      else if (i == int'(FC))
        sb.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
      else
        sb.push_back(mk(32'h0, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL wrap[%0d] got %h exp %h", i, obs, ex);
      end
      if (i == int'(FC)) begin
        checks++;
        if (pc_plus4_o !== 32'h0) begin
          errors++;
          $display("FAIL wrap_plus4 got %h exp 0", pc_plus4_o);
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [116:0] ex;
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h300;
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        clear();
        rst_n = 1'b0;
        exp_cnt = 16'd0;
      end
      if (i == 2) rst_n = 1'b1;
      case (i)
        0: sb.push_back(mk(32'h300, 1'b0, 1'b0, 1'b1, exp_cnt, 1'b0));
        1: sb.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, exp_cnt, 1'b0));
        2: sb.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, exp_cnt, 1'b0));
        default: sb.push_back(mk(32'h4, 1'b1, 1'b1, 1'b0, exp_cnt, 1'b0));
      endcase
      @(posedge clk); #1;
      ex = sb.pop_front();
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL reset_flush[%0d] got %h exp %h", i, obs, ex);
      end
      if (i == 1) begin
        checks++;
        if (trap_tval !== 32'h0) begin
          errors++;
          $display("FAIL reset_flush_tval got %h exp 0", trap_tval);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_boot_fetch();
    test_stall();
    test_not_taken();
    test_branch_priority();
    test_jalr_restart();
    test_misalign();
    test_wrap();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
